instr_prefetch_queue: RTL and testbench

//  Instruction-fetch front end that sits directly upstream of the pipelined cpu.

---
 rtl/instr_prefetch_queue.sv | 125 ++++++++++++
 tb/tb_instr_prefetch_queue.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: streams sequential fetch addresses to a 1-cycle RAM and buffers {instr, pc}.
// Optional INSTR_PREFETCH_BYPASS_EN presents a response directly when the FIFO is empty.
module instr_prefetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        start_pc,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     imem_rd_en,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [DATA_W-1:0]        imem_rdata,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_W-1:0]        instr,
  output logic [ADDR_W-1:0]        instr_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] rec_pc_q, rec_pc_d;
  logic              inflight_q, inflight_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [ADDR_W-1:0] mem_pc_q [DEPTH];

  logic              issue_s, resp_s, empty_s, byp_s, push_s, pop_s;
  logic [CNT_W:0]    pending_s;

  // Handshake decode: issue gating counts the response landing this cycle so a push never overflows.
  always_comb begin
    empty_s   = (count_q == {CNT_W{1'b0}});
    pending_s = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    issue_s   = !rst && !redirect && (pending_s < DEPTH_L);
    resp_s    = inflight_q && !rst && !redirect;
`ifdef INSTR_PREFETCH_BYPASS_EN
    byp_s     = resp_s && empty_s;
`else
    byp_s     = 1'b0;
`endif
    pop_s     = !empty_s && instr_ready && !redirect && !rst;
    push_s    = resp_s && !(byp_s && instr_ready);
  end

  // Output drive from the FIFO head, or the bypassed response when the queue is empty.
  always_comb begin
    imem_rd_en  = issue_s;
    imem_addr   = fpc_q;
    occupancy   = count_q;
    instr_valid = 1'b0;
    instr       = {DATA_W{1'b0}};
    instr_pc    = {ADDR_W{1'b0}};
    if (!empty_s) begin
      instr_valid = 1'b1;
      instr       = mem_data_q[head_q];
      instr_pc    = mem_pc_q[head_q];
    end else if (byp_s) begin
      instr_valid = 1'b1;
      instr       = imem_rdata;
      instr_pc    = rec_pc_q;
    end else begin
      instr_valid = 1'b0;
    end
  end

  // Next-state: reset, then redirect, override the normal fetch/queue advance.
  always_comb begin
    fpc_d      = fpc_q;
    rec_pc_d   = rec_pc_q;
    inflight_d = issue_s;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (rst) begin
      fpc_d    = start_pc;
      rec_pc_d = {ADDR_W{1'b0}};
      head_d   = {PTR_W{1'b0}};
      tail_d   = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else if (redirect) begin
      fpc_d    = redirect_pc;
      head_d   = {PTR_W{1'b0}};
      tail_d   = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (issue_s) begin
        fpc_d    = fpc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        rec_pc_d = fpc_q;
      end else begin
        fpc_d    = fpc_q;
      end
      head_d  = head_q + {{(PTR_W-1){1'b0}}, pop_s};
      tail_d  = tail_q + {{(PTR_W-1){1'b0}}, push_s};
      count_d = count_q + {{(CNT_W-1){1'b0}}, push_s} - {{(CNT_W-1){1'b0}}, pop_s};
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    fpc_q      <= fpc_d;
    rec_pc_q   <= rec_pc_d;
    inflight_q <= inflight_d;
    head_q     <= head_d;
    tail_q     <= tail_d;
    count_q    <= count_d;
  end

  // FIFO storage; contents are never observed while the entry count is zero, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_data_q[tail_q] <= imem_rdata;
      mem_pc_q[tail_q]   <= rec_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue: latency, back-pressure, redirect, wrap and mid-run reset.
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  start_pc = 7'd0;
  logic        redirect = 1'b0;
  logic [6:0]  redirect_pc = 7'd0;
  logic        imem_rd_en;
  logic [6:0]  imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [6:0]  instr_pc;
  logic [2:0]  occupancy;

  int n_vec = 0;
  int n_err = 0;

`ifdef INSTR_PREFETCH_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  instr_prefetch_queue #(.DEPTH(4), .ADDR_W(7), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start_pc(start_pc), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Instruction RAM model: word is a tag plus its address; garbage when not read.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= 32'hC0DE_0000 | {25'd0, imem_addr};
    else            imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reset with given start PC; returns at cycle 0 (rst low), already sampled.
  task automatic do_reset(input logic [6:0] spc, input logic rdy);
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; start_pc = spc; instr_ready = rdy;
    @(negedge clk); #1;
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", 32'(instr_pc), 32'd0);
    check("rst_rden", 32'(imem_rd_en), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'(spc));
    rst = 1'b0; #1;
    check("c0_rden", 32'(imem_rd_en), 32'd1);
    check("c0_addr", 32'(imem_addr), 32'(spc));
    check("c0_valid", 32'(instr_valid), 32'd0);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
    end
  endtask

  // Accept n deliveries with ready=1, expecting consecutive PCs from first.
  task automatic expect_seq(input string tag, input logic [6:0] first, input int n);
    logic [6:0] exp_pc;
    int got;
    exp_pc = first;
    got = 0;
    for (int c = 0; c < 40 && got < n; c++) begin
      @(negedge clk);
      instr_ready = 1'b1;
      #1;
      if (instr_valid) begin
        check({tag, "_pc"}, 32'(instr_pc), 32'(exp_pc));
        check({tag, "_instr"}, instr, 32'hC0DE_0000 | {25'd0, exp_pc});
        exp_pc = exp_pc + 7'd1;
        got++;
      end
    end
    check({tag, "_count"}, 32'(got), 32'(n));
  endtask

  initial begin
    int lat;
    int rd_cnt;

    // 1: start_pc=5, ready=1 -> first valid at cycle EXP_LAT, then one per cycle.
    do_reset(7'd5, 1'b1);
    lat = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk); #1;
      if (instr_valid) begin
        lat = c;
        break;
      end
    end
    check("t1_latency", 32'(lat), 32'(EXP_LAT));
    check("t1_first_pc", 32'(instr_pc), 32'd5);
    check("t1_first_instr", instr, 32'hC0DE_0005);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      check("t1_stream_valid", 32'(instr_valid), 32'd1);
      check("t1_stream_pc", 32'(instr_pc), 32'(7'd6 + 7'(k)));
    end

    // 2: back-pressure for 10 cycles -> 4 reads, full, no issue; then drain in order.
    do_reset(7'd5, 1'b0);
    rd_cnt = 1;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk); #1;
      if (imem_rd_en) rd_cnt++;
    end
    check("t2_reads", 32'(rd_cnt), 32'd4);
    check("t2_occ_full", 32'(occupancy), 32'd4);
    check("t2_rden_off", 32'(imem_rd_en), 32'd0);
    check("t2_head_pc", 32'(instr_pc), 32'd5);
    expect_seq("t2_drain", 7'd5, 8);

    // 3: redirect to 0x40 with 3 queued and 1 in flight.
    do_reset(7'd5, 1'b0);
    step(4);
    check("t3_occ_before", 32'(occupancy), 32'd3);
    redirect = 1'b1; redirect_pc = 7'h40; instr_ready = 1'b1; #1;
    check("t3_rden_redirect", 32'(imem_rd_en), 32'd0);
    @(negedge clk);
    redirect = 1'b0; #1;
    check("t3_occ_after", 32'(occupancy), 32'd0);
    check("t3_valid_after", 32'(instr_valid), 32'd0);
    check("t3_addr_after", 32'(imem_addr), 32'h40);
    check("t3_rden_after", 32'(imem_rd_en), 32'd1);
    expect_seq("t3_seq", 7'h40, 4);

    // 4: PC wrap 126,127,0,1.
    do_reset(7'd126, 1'b1);
    expect_seq("t4_wrap", 7'd126, 4);

    // 5: back-to-back redirects; only the second target is fetched.
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 7'h10; #1;
    check("t5_rden_r1", 32'(imem_rd_en), 32'd0);
    @(negedge clk);
    redirect_pc = 7'h20; #1;
    check("t5_rden_r2", 32'(imem_rd_en), 32'd0);
    @(negedge clk);
    redirect = 1'b0; #1;
    check("t5_valid_after", 32'(instr_valid), 32'd0);
    check("t5_addr_after", 32'(imem_addr), 32'h20);
    expect_seq("t5_seq", 7'h20, 4);

    // 6: rst pulsed while nearly full with a read in flight; restart at new start_pc.
    do_reset(7'd5, 1'b0);
    step(4);
    check("t6_occ_before", 32'(occupancy), 32'd3);
    rst = 1'b1; start_pc = 7'h30; #1;
    check("t6_rden_rst", 32'(imem_rd_en), 32'd0);
    @(negedge clk); #1;
    check("t6_occ_after", 32'(occupancy), 32'd0);
    check("t6_valid_after", 32'(instr_valid), 32'd0);
    rst = 1'b0; instr_ready = 1'b1; #1;
    check("t6_addr_restart", 32'(imem_addr), 32'h30);
    check("t6_rden_restart", 32'(imem_rd_en), 32'd1);
    expect_seq("t6_seq", 7'h30, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
